// File: rtl/sef_echo_buffer.sv
// Buffered echo core: circular buffer between receiver and transmitter, in stream or file replay mode.
// Latency: 2 cycles from new_data to req when idle in stream mode; each word is held on tx_data until ack.
module sef_echo_buffer #(
  parameter int NUM_BITS    = 8,
  parameter int DEPTH       = 2048,
  parameter int IDLE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_data,
  input  logic [NUM_BITS-1:0] rx_data,
  input  logic                mode,
  output logic                req,
  input  logic                ack,
  output logic [NUM_BITS-1:0] tx_data,
  output logic [31:0]         bcd_counter,
  output logic [7:0]          mask_n,
  output logic                overflow,
  output logic                busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t              state;
  logic                play;
  logic [NUM_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [AW:0]         count_next;
  logic [TW-1:0]       timer;
  logic                accept;
  logic                ack_fire;
  logic                carry;
  logic                seen;
  logic [31:0]         bcd_inc;
  logic [31:0]         bcd_next;
  logic [7:0]          mask_next;

  assign accept   = new_data && (count != FULL);
  assign ack_fire = (state == SEND) && ack;
  assign busy     = (state != IDLE);

  always_comb begin
    count_next = count;
    if (accept && !ack_fire)
      count_next = count + 1'b1;
    else if (ack_fire && !accept)
      count_next = count - 1'b1;
  end

  // Decimal increment with ripple carry, pinned at 9999_9999.
  always_comb begin
    carry   = 1'b1;
    bcd_inc = bcd_counter;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (bcd_counter[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_counter[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (bcd_counter == 32'h9999_9999)
      bcd_inc = bcd_counter;
  end

  // A finished file playback restarts the count; an accept cannot coincide with it.
  always_comb begin
    bcd_next = bcd_counter;
    if (ack_fire && play && (count_next == '0))
      bcd_next = '0;
    else if (accept)
      bcd_next = bcd_inc;
  end

  always_comb begin
    mask_next = 8'hFF;
    seen      = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd_next[4*i +: 4] != 4'd0)
        seen = 1'b1;
      if (seen || (i == 0))
        mask_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      count       <= '0;
      timer       <= '0;
      overflow    <= 1'b0;
      bcd_counter <= '0;
      mask_n      <= 8'hFE;
    end else begin
      count       <= count_next;
      bcd_counter <= bcd_next;
      mask_n      <= mask_next;
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (new_data && !accept)
        overflow <= 1'b1;
      if (new_data)
        timer <= '0;
      else if (timer != TMAX)
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      play    <= 1'b0;
      rd_ptr  <= '0;
      req     <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && (!mode || (timer == TMAX))) begin
            state <= LOAD;
            play  <= mode;
          end
        end
        LOAD: begin
          tx_data <= mem[rd_ptr];
          req     <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (ack) begin
            rd_ptr <= rd_ptr + 1'b1;
            req    <= 1'b0;
            state  <= (play && (count_next != '0)) ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sef_echo_buffer.sv
// Scoreboard bench for sef_echo_buffer: a queue model of the buffer feeds expected words to an ack responder.
module tb_sef_echo_buffer;
  localparam int NB    = 8;
  localparam int DEPTH = 4;
  localparam int IDLE  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          new_data;
  logic [NB-1:0] rx_data;
  logic          mode;
  logic          req;
  logic          ack;
  logic [NB-1:0] tx_data;
  logic [31:0]   bcd_counter;
  logic [7:0]    mask_n;
  logic          overflow;
  logic          busy;

  sef_echo_buffer #(.NUM_BITS(NB), .DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .new_data(new_data), .rx_data(rx_data), .mode(mode),
    .req(req), .ack(ack), .tx_data(tx_data), .bcd_counter(bcd_counter),
    .mask_n(mask_n), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          n_acc  = 0;
  bit          exp_ovf = 1'b0;
  bit          ack_en  = 1'b0;
  int          ack_min = 0;
  int          ack_max = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_mask(input int v);
    logic [7:0] m;
    int p = 1;
    for (int i = 0; i < 8; i++) begin
      m[i] = !((i == 0) || (v >= p));
      p = p * 10;
    end
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Drives a strobe in the current cycle; the model accepts unless the buffer was full before the edge.
  task automatic send_now(input logic [7:0] d);
    new_data = 1'b1;
    rx_data  = d;
    if (exp_q.size() + int'(ack) < DEPTH) begin
      exp_q.push_back(d);
      if (n_acc < 99999999) n_acc++;
    end else begin
      exp_ovf = 1'b1;
    end
    tick();
    new_data = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tick();
    send_now(d);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || req || exp_q.size() != 0) && k < 2000) begin
      tick();
      k++;
    end
    check({name, "_drained"}, longint'(k < 2000), 1);
  endtask

  // Ack responder and scoreboard monitor: compares each presented word when it is acked.
  initial begin
    int wait_cnt = 0;
    bit seen_req = 1'b0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (!req || !rst_n) begin
        seen_req = 1'b0;
      end else if (ack_en) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          wait_cnt = $urandom_range(ack_max, ack_min);
        end
        if (wait_cnt == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: tx_data %0h with nothing expected", tx_data);
          end else begin
            check("tx_data", tx_data, exp_q.pop_front());
          end
          ack = 1'b1;
          seen_req = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    int k;
    rst_n    = 1'b0;
    new_data = 1'b0;
    rx_data  = '0;
    mode     = 1'b0;
    tick();
    check("rst_req", req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_bcd", bcd_counter, 0);
    check("rst_mask", mask_n, 8'hFE);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;

    // Stream mode single word and its latency.
    ack_en = 1'b1; ack_min = 5; ack_max = 5;
    send(8'h41);
    check("lat_e0_req", req, 0);
    tick();
    check("lat_e1_req", req, 0);
    tick();
    check("lat_e2_req", req, 1);
    check("lat_e2_tx", tx_data, 8'h41);
    wait_idle("stream1");
    check("stream1_bcd", bcd_counter, to_bcd(n_acc));
    check("stream1_mask", mask_n, exp_mask(n_acc));
    check("stream1_busy", busy, 0);

    // File mode: collect, wait for silence, replay.
    mode = 1'b1; ack_min = 3; ack_max = 3;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h30 + i));
      if (i < 3) repeat (9) tick();
    end
    quiet = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (req) quiet = 1'b0;
    end
    check("file_quiet", quiet, 1);
    tick();
    check("file_req_after_idle", req, 1);
    check("file_bcd_play", bcd_counter, to_bcd(n_acc));
    wait_idle("file");
    n_acc = 0;
    check("file_bcd_end", bcd_counter, to_bcd(n_acc));
    check("file_mask_end", mask_n, exp_mask(n_acc));
    check("file_busy_end", busy, 0);

    // Overflow in file mode.
    for (int i = 1; i <= 6; i++) begin
      send(8'(i));
      if (i == 4) check("ovf_after4", overflow, exp_ovf);
      if (i == 5) check("ovf_after5", overflow, exp_ovf);
      tick();
    end
    check("ovf_bcd_peak", bcd_counter, to_bcd(n_acc));
    wait_idle("ovf");
    n_acc = 0;
    check("ovf_bcd_end", bcd_counter, to_bcd(n_acc));
    check("ovf_sticky", overflow, 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete(); n_acc = 0; exp_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Stream mode with writes landing on every ack; pointers wrap.
    mode = 1'b0; ack_min = 3; ack_max = 3;
    send(8'hA0);
    send(8'hA1);
    for (int w = 0; w < 8; w++) begin
      k = 0;
      while (!ack && k < 100) begin
        tick();
        k++;
      end
      check("sim_ack_seen", longint'(k < 100), 1);
      send_now(8'(8'h80 + w));
      check("sim_count", dut.count, 2);
    end
    wait_idle("sim");
    check("sim_ovf", overflow, exp_ovf);
    check("bcd10", bcd_counter, to_bcd(n_acc));
    check("mask10", mask_n, exp_mask(n_acc));

    // Random stream traffic up to 100 words.
    ack_min = 0; ack_max = 3;
    for (int i = 0; i < 90; i++) begin
      send(8'($urandom));
      repeat ($urandom_range(7, 9)) tick();
    end
    wait_idle("rand");
    check("bcd100", bcd_counter, to_bcd(n_acc));
    check("mask100", mask_n, exp_mask(n_acc));
    check("rand_ovf", overflow, exp_ovf);

    // Saturation at 9999_9999.
    force dut.bcd_counter = 32'h9999_9999;
    n_acc = 99999999;
    send(8'h5A);
    check("sat_mask", mask_n, exp_mask(n_acc));
    release dut.bcd_counter;
    tick();
    check("sat_hold", bcd_counter, to_bcd(n_acc));
    send(8'hA5);
    check("sat_hold2", bcd_counter, to_bcd(n_acc));
    wait_idle("sat");

    // Asynchronous reset while a word is presented.
    ack_en = 1'b0;
    send(8'h77);
    k = 0;
    while (!req && k < 20) begin
      tick();
      k++;
    end
    check("rst_mid_req_seen", req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_req", req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tx", tx_data, 0);
    exp_q.delete(); n_acc = 0; exp_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    ack_en = 1'b1;
    check("rst_mid_count", dut.count, 0);
    check("rst_mid_bcd", bcd_counter, to_bcd(n_acc));
    quiet = 1'b1;
    repeat (10) begin
      tick();
      if (req || busy) quiet = 1'b0;
    end
    check("rst_mid_quiet", quiet, 1);
    send(8'h99);
    wait_idle("post_rst");
    check("post_rst_bcd", bcd_counter, to_bcd(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
